// File: rtl/cci_mpf_if_pkg.sv
// Purpose: base CCI and MPF-extended request channel types plus edge-stage helpers.
// Latency: n/a (types, constants and pure combinational conversion functions).
// Backpressure: n/a.
package cci_mpf_if_pkg;

    localparam int CCI_CLADDR_WIDTH                = 42;
    localparam int CCI_MDATA_WIDTH                 = 16;
    localparam int CCI_CLDATA_WIDTH                = 512;
    localparam int CCI_ALMOST_FULL_THRESHOLD       = 2;
    localparam int CCI_MPF_EDGE_FIFO_DEPTH_DEFAULT = 8;

    // Base CCI request header, shared by reads and writes.
    typedef struct packed {
        logic [3:0]                  req_type;
        logic [CCI_CLADDR_WIDTH-1:0] address;
        logic [CCI_MDATA_WIDTH-1:0]  mdata;
    } t_cci_ReqMemHdr;

    // MPF extension carried alongside the base header inside the MPF pipeline.
    typedef struct packed {
        logic       addrIsVirtual;
        logic       checkLoadStoreOrder;
        logic [3:0] addressExt;
    } t_cci_mpf_ReqMemHdrExt;

    typedef struct packed {
        t_cci_mpf_ReqMemHdrExt ext;
        t_cci_ReqMemHdr        base;
    } t_cci_mpf_ReqMemHdr;

    typedef struct packed {
        t_cci_ReqMemHdr hdr;
        logic           rdValid;
    } t_if_cci_c0_Tx;

    typedef struct packed {
        t_cci_ReqMemHdr              hdr;
        logic [CCI_CLDATA_WIDTH-1:0] data;
        logic                        wrValid;
        logic                        intrValid;
    } t_if_cci_c1_Tx;

    typedef struct packed {
        t_cci_mpf_ReqMemHdr hdr;
        logic               rdValid;
    } t_if_cci_mpf_c0_Tx;

    typedef struct packed {
        t_cci_mpf_ReqMemHdr          hdr;
        logic [CCI_CLDATA_WIDTH-1:0] data;
        logic                        wrValid;
        logic                        intrValid;
    } t_if_cci_mpf_c1_Tx;

    // Drop the MPF extension; the base header passes through bit-for-bit.
    function automatic t_if_cci_c0_Tx cci_mpf_c0TxToBase(input t_if_cci_mpf_c0_Tx r);
        t_if_cci_c0_Tx c;
        c.hdr     = r.hdr.base;
        c.rdValid = r.rdValid;
        return c;
    endfunction

    function automatic t_if_cci_c1_Tx cci_mpf_c1TxToBase(input t_if_cci_mpf_c1_Tx r);
        t_if_cci_c1_Tx c;
        c.hdr       = r.hdr.base;
        c.data      = r.data;
        c.wrValid   = r.wrValid;
        c.intrValid = r.intrValid;
        return c;
    endfunction

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Purpose: small distributed-RAM FIFO. Ports: clk, reset (async active-high), enq_en/enq_data,
//          deq_en, first (head entry, combinational), notEmpty, notFull, almostFull.
// Latency: an entry written on one edge is visible on first after that edge; a full FIFO drops an
//          enqueue unless a dequeue happens in the same cycle.
module cci_mpf_prim_fifo_lutram #(
    parameter int N_DATA_BITS = 32,
    parameter int N_ENTRIES   = 8,
    parameter int THRESHOLD   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_en,
    input  logic [N_DATA_BITS-1:0] enq_data,
    input  logic                   deq_en,
    output logic [N_DATA_BITS-1:0] first,
    output logic                   notEmpty,
    output logic                   notFull,
    output logic                   almostFull
);
    localparam int PTR_W = $clog2(N_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   w_deq;
    logic                   w_enq;

    assign notEmpty   = (r_count != '0);
    assign notFull    = (r_count != CNT_W'(N_ENTRIES));
    assign almostFull = (r_count >= CNT_W'(N_ENTRIES - THRESHOLD));
    assign first      = r_mem[r_rd_ptr];

    assign w_deq = deq_en & notEmpty;
    // When full, the slot being written is the one being read out this same edge.
    assign w_enq = enq_en & (notFull | w_deq);

    // Storage is not reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cci_mpf_shim_edge_fiu.sv
// Purpose: last MPF stage before the FIU; per-channel FIFO, strips the MPF header extension,
//          emits registered base CCI requests and sticky overflow / virtual-address error flags.
//          Ports: clk, reset, afu_c0Tx/afu_c1Tx in, afu_c*TxAlmFull out, fiu_c*Tx out,
//          fiu_c*TxAlmFull in, err_overflow[1:0], err_vaddr[1:0] (bit0 = c0, bit1 = c1).
// Latency: 2 cycles enqueue-to-output on an empty FIFO; channels are independent.
// Backpressure: fiu_c*TxAlmFull stalls dequeue; afu_c*TxAlmFull asserts at
//          N_ENTRIES - ALM_FULL_SLACK entries. Optional macro CCI_MPF_EDGE_VADDR_CHECK_EN
//          drops virtual-address requests and flags err_vaddr.
module cci_mpf_shim_edge_fiu
    import cci_mpf_if_pkg::*;
#(
    parameter int N_ENTRIES      = CCI_MPF_EDGE_FIFO_DEPTH_DEFAULT,
    parameter int ALM_FULL_SLACK = CCI_ALMOST_FULL_THRESHOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  t_if_cci_mpf_c0_Tx afu_c0Tx,
    output logic              afu_c0TxAlmFull,
    input  t_if_cci_mpf_c1_Tx afu_c1Tx,
    output logic              afu_c1TxAlmFull,
    output t_if_cci_c0_Tx     fiu_c0Tx,
    input  logic              fiu_c0TxAlmFull,
    output t_if_cci_c1_Tx     fiu_c1Tx,
    input  logic              fiu_c1TxAlmFull,
    output logic [1:0]        err_overflow,
    output logic [1:0]        err_vaddr
);
    t_if_cci_c0_Tx w_c0_enq_dat, w_c0_first;
    t_if_cci_c1_Tx w_c1_enq_dat, w_c1_first;
    logic          w_c0_enq, w_c0_deq, w_c0_not_empty, w_c0_not_full;
    logic          w_c1_enq, w_c1_deq, w_c1_not_empty, w_c1_not_full;
    logic [1:0]    w_overflow;
    logic          w_unused_ext;

    t_if_cci_c0_Tx r_fiu_c0Tx;
    t_if_cci_c1_Tx r_fiu_c1Tx;
    logic [1:0]    r_err_overflow;

    // Extension is converted away before storage, so only base fields occupy FIFO bits.
    assign w_c0_enq_dat = cci_mpf_c0TxToBase(afu_c0Tx);
    assign w_c1_enq_dat = cci_mpf_c1TxToBase(afu_c1Tx);
    assign w_unused_ext = ^{afu_c0Tx.hdr.ext, afu_c1Tx.hdr.ext};

`ifdef CCI_MPF_EDGE_VADDR_CHECK_EN
    logic       w_c0_virt, w_c1_virt;
    logic [1:0] r_err_vaddr;

    assign w_c0_virt = afu_c0Tx.rdValid & afu_c0Tx.hdr.ext.addrIsVirtual;
    assign w_c1_virt = (afu_c1Tx.wrValid | afu_c1Tx.intrValid) & afu_c1Tx.hdr.ext.addrIsVirtual;
    assign w_c0_enq  = afu_c0Tx.rdValid & ~w_c0_virt;
    assign w_c1_enq  = (afu_c1Tx.wrValid | afu_c1Tx.intrValid) & ~w_c1_virt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_vaddr <= '0;
        end else begin
            r_err_vaddr <= r_err_vaddr | {w_c1_virt, w_c0_virt};
        end
    end
    assign err_vaddr = r_err_vaddr;
`else
    assign w_c0_enq  = afu_c0Tx.rdValid;
    assign w_c1_enq  = afu_c1Tx.wrValid | afu_c1Tx.intrValid;
    assign err_vaddr = 2'b00;
`endif

    assign w_c0_deq = w_c0_not_empty & ~fiu_c0TxAlmFull;
    assign w_c1_deq = w_c1_not_empty & ~fiu_c1TxAlmFull;

    // A dequeue in the same cycle frees the slot, so only full-and-stalled is an overflow.
    assign w_overflow[0] = w_c0_enq & ~w_c0_not_full & ~w_c0_deq;
    assign w_overflow[1] = w_c1_enq & ~w_c1_not_full & ~w_c1_deq;

    cci_mpf_prim_fifo_lutram #(
        .N_DATA_BITS ($bits(t_if_cci_c0_Tx)),
        .N_ENTRIES   (N_ENTRIES),
        .THRESHOLD   (ALM_FULL_SLACK)
    ) u_c0_fifo (
        .clk        (clk),
        .reset      (reset),
        .enq_en     (w_c0_enq),
        .enq_data   (w_c0_enq_dat),
        .deq_en     (w_c0_deq),
        .first      (w_c0_first),
        .notEmpty   (w_c0_not_empty),
        .notFull    (w_c0_not_full),
        .almostFull (afu_c0TxAlmFull)
    );

    cci_mpf_prim_fifo_lutram #(
        .N_DATA_BITS ($bits(t_if_cci_c1_Tx)),
        .N_ENTRIES   (N_ENTRIES),
        .THRESHOLD   (ALM_FULL_SLACK)
    ) u_c1_fifo (
        .clk        (clk),
        .reset      (reset),
        .enq_en     (w_c1_enq),
        .enq_data   (w_c1_enq_dat),
        .deq_en     (w_c1_deq),
        .first      (w_c1_first),
        .notEmpty   (w_c1_not_empty),
        .notFull    (w_c1_not_full),
        .almostFull (afu_c1TxAlmFull)
    );

    // Stored entries carry their own valid flags; idle cycles drive an all-zero request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fiu_c0Tx     <= '0;
            r_fiu_c1Tx     <= '0;
            r_err_overflow <= '0;
        end else begin
            r_fiu_c0Tx     <= w_c0_deq ? w_c0_first : '0;
            r_fiu_c1Tx     <= w_c1_deq ? w_c1_first : '0;
            r_err_overflow <= r_err_overflow | w_overflow;
        end
    end

    assign fiu_c0Tx     = r_fiu_c0Tx;
    assign fiu_c1Tx     = r_fiu_c1Tx;
    assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_cci_mpf_shim_edge_fiu.sv
module tb_cci_mpf_shim_edge_fiu;
    import cci_mpf_if_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    t_if_cci_mpf_c0_Tx afu_c0Tx;
    t_if_cci_mpf_c1_Tx afu_c1Tx;
    logic              afu_c0TxAlmFull, afu_c1TxAlmFull;
    t_if_cci_c0_Tx     fiu_c0Tx;
    t_if_cci_c1_Tx     fiu_c1Tx;
    logic              fiu_c0TxAlmFull, fiu_c1TxAlmFull;
    logic [1:0]        err_overflow, err_vaddr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cci_mpf_shim_edge_fiu #(.N_ENTRIES(8), .ALM_FULL_SLACK(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .afu_c0Tx        (afu_c0Tx),
        .afu_c0TxAlmFull (afu_c0TxAlmFull),
        .afu_c1Tx        (afu_c1Tx),
        .afu_c1TxAlmFull (afu_c1TxAlmFull),
        .fiu_c0Tx        (fiu_c0Tx),
        .fiu_c0TxAlmFull (fiu_c0TxAlmFull),
        .fiu_c1Tx        (fiu_c1Tx),
        .fiu_c1TxAlmFull (fiu_c1TxAlmFull),
        .err_overflow    (err_overflow),
        .err_vaddr       (err_vaddr)
    );

    task automatic idle();
        afu_c0Tx = '0;
        afu_c1Tx = '0;
    endtask

    task automatic rd(input logic [41:0] a, input logic [15:0] m, input logic virt);
        afu_c0Tx = '0;
        afu_c0Tx.hdr.base.address      = a;
        afu_c0Tx.hdr.base.mdata        = m;
        afu_c0Tx.hdr.ext.addrIsVirtual = virt;
        afu_c0Tx.rdValid               = 1'b1;
    endtask

    task automatic wr(input logic [31:0] d, input logic w, input logic intr);
        afu_c1Tx = '0;
        afu_c1Tx.hdr.base.address = 42'h100 + 42'(d);
        afu_c1Tx.hdr.base.mdata   = d[15:0];
        afu_c1Tx.data             = {480'b0, d};
        afu_c1Tx.wrValid          = w;
        afu_c1Tx.intrValid        = intr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fiu_c0TxAlmFull = 1'b0;
        fiu_c1TxAlmFull = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        n_vec++; if ({fiu_c0Tx.rdValid, fiu_c1Tx.wrValid, fiu_c1Tx.intrValid} !== 3'b000) begin n_err++; $display("FAIL reset_valids got %b want 000", {fiu_c0Tx.rdValid, fiu_c1Tx.wrValid, fiu_c1Tx.intrValid}); end
        n_vec++; if ({afu_c0TxAlmFull, afu_c1TxAlmFull} !== 2'b00) begin n_err++; $display("FAIL reset_almfull got %b want 00", {afu_c0TxAlmFull, afu_c1TxAlmFull}); end
        n_vec++; if ({err_overflow, err_vaddr} !== 4'b0000) begin n_err++; $display("FAIL reset_errs got %b want 0000", {err_overflow, err_vaddr}); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if ({fiu_c0Tx.rdValid, fiu_c1Tx.wrValid} !== 2'b00) begin n_err++; $display("FAIL post_reset_valids got %b want 00", {fiu_c0Tx.rdValid, fiu_c1Tx.wrValid}); end
    endtask

    task automatic test_single_read();
        @(negedge clk); rd(42'h1234, 16'h5, 1'b0);
        @(negedge clk); idle();
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b0) begin n_err++; $display("FAIL single_rd_early got %b want 0", fiu_c0Tx.rdValid); end
        @(negedge clk);
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b1) begin n_err++; $display("FAIL single_rd_valid got %b want 1", fiu_c0Tx.rdValid); end
        n_vec++; if (fiu_c0Tx.hdr.address !== 42'h1234) begin n_err++; $display("FAIL single_rd_addr got %h want 1234", fiu_c0Tx.hdr.address); end
        n_vec++; if (fiu_c0Tx.hdr.mdata !== 16'h5) begin n_err++; $display("FAIL single_rd_mdata got %h want 5", fiu_c0Tx.hdr.mdata); end
        n_vec++; if (afu_c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL single_rd_almfull got %b want 0", afu_c0TxAlmFull); end
        @(negedge clk);
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b0) begin n_err++; $display("FAIL single_rd_after got %b want 0", fiu_c0Tx.rdValid); end
    endtask

    task automatic test_interrupt();
        @(negedge clk); wr(32'h77, 1'b0, 1'b1);
        @(negedge clk); idle();
        @(negedge clk);
        n_vec++; if ({fiu_c1Tx.intrValid, fiu_c1Tx.wrValid} !== 2'b10) begin n_err++; $display("FAIL intr_flags got %b want 10", {fiu_c1Tx.intrValid, fiu_c1Tx.wrValid}); end
        n_vec++; if (fiu_c1Tx.data[31:0] !== 32'h77) begin n_err++; $display("FAIL intr_data got %h want 77", fiu_c1Tx.data[31:0]); end
    endtask

    task automatic test_backpressure();
        fiu_c0TxAlmFull = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); rd(42'h100 + 42'(i), 16'(i), 1'b0);
            n_vec++; if (afu_c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL bp_alm_low[%0d] got %b want 0", i, afu_c0TxAlmFull); end
            n_vec++; if (fiu_c0Tx.rdValid !== 1'b0) begin n_err++; $display("FAIL bp_held[%0d] got %b want 0", i, fiu_c0Tx.rdValid); end
        end
        @(negedge clk); idle();
        n_vec++; if (afu_c0TxAlmFull !== 1'b1) begin n_err++; $display("FAIL bp_alm_rise got %b want 1", afu_c0TxAlmFull); end
        fiu_c0TxAlmFull = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++; if (fiu_c0Tx.rdValid !== 1'b1 || fiu_c0Tx.hdr.address !== 42'h100 + 42'(i)) begin n_err++; $display("FAIL bp_out[%0d] got v=%b a=%h want v=1 a=%h", i, fiu_c0Tx.rdValid, fiu_c0Tx.hdr.address, 42'h100 + 42'(i)); end
            if (i == 0) begin
                n_vec++; if (afu_c0TxAlmFull !== 1'b0) begin n_err++; $display("FAIL bp_alm_drop got %b want 0", afu_c0TxAlmFull); end
            end
        end
        @(negedge clk);
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", fiu_c0Tx.rdValid); end
    endtask

    task automatic test_overflow();
        fiu_c1TxAlmFull = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); wr(32'(i), 1'b1, 1'b0);
            if (i == 8) begin
                n_vec++; if (err_overflow !== 2'b00) begin n_err++; $display("FAIL ovf_early got %b want 00", err_overflow); end
            end
        end
        @(negedge clk); idle();
        n_vec++; if (err_overflow !== 2'b10) begin n_err++; $display("FAIL ovf_flag got %b want 10", err_overflow); end
        n_vec++; if (afu_c1TxAlmFull !== 1'b1) begin n_err++; $display("FAIL ovf_almfull got %b want 1", afu_c1TxAlmFull); end
        fiu_c1TxAlmFull = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_vec++; if (fiu_c1Tx.wrValid !== 1'b1 || fiu_c1Tx.data !== {480'b0, 32'(i)}) begin n_err++; $display("FAIL ovf_out[%0d] got v=%b d=%h want v=1 d=%h", i, fiu_c1Tx.wrValid, fiu_c1Tx.data[31:0], i); end
        end
        @(negedge clk);
        n_vec++; if (fiu_c1Tx.wrValid !== 1'b0) begin n_err++; $display("FAIL ovf_ninth_dropped got %b want 0", fiu_c1Tx.wrValid); end
        n_vec++; if (err_overflow !== 2'b10) begin n_err++; $display("FAIL ovf_sticky got %b want 10", err_overflow); end
    endtask

    task automatic test_vaddr();
        @(negedge clk); rd(42'h2000, 16'h9, 1'b1);
        @(negedge clk); rd(42'h3000, 16'hA, 1'b0);
        @(negedge clk); idle();
`ifdef CCI_MPF_EDGE_VADDR_CHECK_EN
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b0) begin n_err++; $display("FAIL vaddr_dropped got %b want 0", fiu_c0Tx.rdValid); end
        n_vec++; if (err_vaddr !== 2'b01) begin n_err++; $display("FAIL vaddr_flag got %b want 01", err_vaddr); end
`else
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b1 || fiu_c0Tx.hdr.address !== 42'h2000) begin n_err++; $display("FAIL vaddr_forward got v=%b a=%h want v=1 a=2000", fiu_c0Tx.rdValid, fiu_c0Tx.hdr.address); end
        n_vec++; if (err_vaddr !== 2'b00) begin n_err++; $display("FAIL vaddr_tied got %b want 00", err_vaddr); end
`endif
        @(negedge clk);
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b1 || fiu_c0Tx.hdr.address !== 42'h3000 || fiu_c0Tx.hdr.mdata !== 16'hA) begin n_err++; $display("FAIL vaddr_phys got v=%b a=%h m=%h want v=1 a=3000 m=a", fiu_c0Tx.rdValid, fiu_c0Tx.hdr.address, fiu_c0Tx.hdr.mdata); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); rd(42'h400 + 42'(i), 16'(i), 1'b0);
        end
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b1 || fiu_c0Tx.hdr.address !== 42'h401) begin n_err++; $display("FAIL rstmid_pre got v=%b a=%h want v=1 a=401", fiu_c0Tx.rdValid, fiu_c0Tx.hdr.address); end
        n_vec++; if (err_overflow !== 2'b10) begin n_err++; $display("FAIL rstmid_err_pre got %b want 10", err_overflow); end
        #1 reset = 1'b1;
        #1;
        n_vec++; if (fiu_c0Tx.rdValid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", fiu_c0Tx.rdValid); end
        n_vec++; if ({err_overflow, err_vaddr} !== 4'b0000) begin n_err++; $display("FAIL rstmid_errs got %b want 0000", {err_overflow, err_vaddr}); end
        @(negedge clk); idle(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (fiu_c0Tx.rdValid !== 1'b0) begin n_err++; $display("FAIL rstmid_flushed[%0d] got %b want 0", i, fiu_c0Tx.rdValid); end
        end
    endtask

    task automatic test_full_simul();
        fiu_c1TxAlmFull = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); wr(32'h20 + 32'(i), 1'b1, 1'b0);
        end
        @(negedge clk); wr(32'h28, 1'b1, 1'b0);
        fiu_c1TxAlmFull = 1'b0;
        n_vec++; if (afu_c1TxAlmFull !== 1'b1 || fiu_c1Tx.wrValid !== 1'b0) begin n_err++; $display("FAIL full_pre got alm=%b v=%b want alm=1 v=0", afu_c1TxAlmFull, fiu_c1Tx.wrValid); end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) idle();
            n_vec++; if (fiu_c1Tx.wrValid !== 1'b1 || fiu_c1Tx.data !== {480'b0, 32'h20 + 32'(i)}) begin n_err++; $display("FAIL full_out[%0d] got v=%b d=%h want v=1 d=%h", i, fiu_c1Tx.wrValid, fiu_c1Tx.data[31:0], 32'h20 + 32'(i)); end
        end
        @(negedge clk);
        n_vec++; if (fiu_c1Tx.wrValid !== 1'b0) begin n_err++; $display("FAIL full_drained got %b want 0", fiu_c1Tx.wrValid); end
        n_vec++; if (err_overflow !== 2'b00) begin n_err++; $display("FAIL full_no_ovf got %b want 00", err_overflow); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_interrupt();
        test_backpressure();
        test_overflow();
        test_vaddr();
        test_reset_mid();
        test_full_simul();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cci_mpf_shim_edge_fiu.md
Name: cci_mpf_shim_edge_fiu

Overview:
- Final MPF stage before the physical CCI (FIU side); consumes MPF-extended c0/c1 request channels.
- Buffers each channel in a small FIFO, strips the MPF header extension, and emits base CCI requests.
- Honours FIU almost-full and generates almost-full back to the MPF pipeline.
- Flags protocol violations (overflow; untranslated virtual address) with sticky error bits.

Parameters:
- N_ENTRIES, 8, per-channel FIFO depth; power of 2, minimum 4.
- ALM_FULL_SLACK, CCI_ALMOST_FULL_THRESHOLD, free entries remaining when afu_*AlmFull asserts.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- afu_c0Tx  in  $bits(t_if_cci_mpf_c0_Tx)  MPF read requests
- afu_c0TxAlmFull  out  1  c0 backpressure to MPF
- afu_c1Tx  in  $bits(t_if_cci_mpf_c1_Tx)  MPF write/interrupt requests
- afu_c1TxAlmFull  out  1  c1 backpressure to MPF
- fiu_c0Tx  out  $bits(t_if_cci_c0_Tx)  base CCI read requests, registered
- fiu_c0TxAlmFull  in  1  FIU c0 almost full
- fiu_c1Tx  out  $bits(t_if_cci_c1_Tx)  base CCI write requests, registered
- fiu_c1TxAlmFull  in  1  FIU c1 almost full
- err_overflow  out  2  sticky; bit0 = c0, bit1 = c1 enqueue while full
- err_vaddr  out  2  sticky; virtual-address request reached the edge

Behaviour:
- One clock. Reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values:
  - FIFOs empty.
  - All fiu_* valid bits 0; headers/data don't-care.
  - afu_*AlmFull = 0.
  - err_* = 0.
- Enqueue conditions:
  - c0 enqueues when rdValid = 1.
  - c1 enqueues when wrValid | intrValid; both flags are stored in the entry.
- Almost-full: afu_cNTxAlmFull = (occupancy >= N_ENTRIES - ALM_FULL_SLACK), computed from the registered count (count after the current cycle's update).
- Dequeue:
  - Channel N dequeues one entry per cycle when non-empty and fiu_cNTxAlmFull = 0.
  - The entry is registered onto fiu_cNTx the next cycle, so enqueue-to-output latency is 2 cycles on an empty FIFO.
  - In every cycle with no dequeue, output valids are 0.
- Header conversion: fiu hdr = entry hdr.base, bit-for-bit; ext is discarded; mdata is preserved.
- Simultaneous enqueue and dequeue: occupancy is unchanged. A full FIFO with a simultaneous dequeue accepts the enqueue without overflow.
- Enqueue while full with no dequeue:
  - The request is dropped and err_overflow[N] sets.
  - Pointers and count are unchanged.
- Pointers wrap modulo N_ENTRIES. Count is $clog2(N_ENTRIES)+1 bits wide.
- c0 and c1 are fully independent; no cross-channel ordering is enforced. The upstream MPF order stage owns that ordering.
- Sticky errors clear only on reset.
- Reset mid-operation: in-flight entries are discarded and outputs go invalid asynchronously.

Optional Feature:
- Macro: CCI_MPF_EDGE_VADDR_CHECK_EN.
- Defined:
  - An enqueue whose hdr.ext.addrIsVirtual = 1 is dropped and not stored.
  - err_vaddr[N] sets.
  - Occupancy is unaffected.
- Undefined:
  - addrIsVirtual is ignored, the request is forwarded with base.address as-is, and err_vaddr is tied 0.
  - No check logic is synthesised.

Decomposition:
- Add to cci_mpf_if_pkg:
  - helper function cci_mpf_c0TxToBase(t_if_cci_mpf_c0_Tx) returning t_if_cci_c0_Tx;
  - c1 equivalent cci_mpf_c1TxToBase(t_if_cci_mpf_c1_Tx) returning t_if_cci_c1_Tx;
  - constant CCI_MPF_EDGE_FIFO_DEPTH_DEFAULT = 8.
- One natural sub-module: cci_mpf_prim_fifo_lutram.
  - Parameterised width/depth.
  - Interfaces: enq_en, enq_data, deq_en, first, notEmpty, notFull, almostFull, with async active-high reset.
  - Instantiated once per channel.

Test Plan:
- c0: single read, address 0x1234, mdata 0x5, ext.addressExt = 0, with FIU not almost-full -> fiu_c0Tx.rdValid = 1 exactly 2 cycles later with address 0x1234, mdata 0x5; afu_c0TxAlmFull stays 0.
- Backpressure:
  - Stimulus: N_ENTRIES = 8, ALM_FULL_SLACK = 2, fiu_c0TxAlmFull = 1; 6 reads in consecutive cycles.
  - Response: afu_c0TxAlmFull rises the cycle after the 6th enqueue.
  - Release fiu_c0TxAlmFull -> 6 outputs in order on consecutive cycles; AlmFull drops when occupancy reaches 5.
- Overflow: fiu_c1TxAlmFull = 1; 9 writes with data 0..8 -> err_overflow = 2'b10; the 9th write is absent from output after release; outputs carry data 0..7 in order.
- Full plus simultaneous dequeue: FIFO at 8 entries with fiu_c1TxAlmFull released in the same cycle as a 9th write -> no overflow error; 9 writes emerge in order.
- Interrupt: c1 with intrValid = 1, wrValid = 0 -> fiu_c1Tx.intrValid = 1, wrValid = 0, 2 cycles later.
- With CCI_MPF_EDGE_VADDR_CHECK_EN: read with addrIsVirtual = 1 -> no fiu output and err_vaddr = 2'b01; a following physical read passes normally. Assert reset mid-burst -> all valids 0 and errors cleared immediately.
